dvi_bw_rx: RTL
==============

# dvi_bw_rx

Single-channel receiver for the black/white DVI stream. It takes DDR-sampled TMDS bit pairs, recovers the 10-bit symbol boundary by searching for the blanking token, and decodes each symbol into pixel-rate `de`/`dat` strobes with a lock indication. It sits behind the board's DDR input cells, with `clk_i` at 5× pixel rate frequency-locked to the transmitter, and feeds pixel-domain consumers such as the capture and loopback checkers.

## Interface
- `LOCK_RUN`, default 16: number of consecutive `CTL_00` symbols at one offset required to declare lock.
- `UNLOCK_ERR`, default 4: number of consecutive invalid symbols while locked that forces loss of lock.
- `clk_i`, in, 1: bit clock at 5× pixel rate. Two bits are received per cycle.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `tmds_re_i`, in, 1: bit captured on the rising edge. It is the earlier bit of the pair.
- `tmds_fe_i`, in, 1: bit captured on the falling edge. It is the later bit of the pair.
- `valid_o`, out, 1: one-cycle pulse per decoded symbol while locked.
- `de_o`, out, 1: data enable of the last symbol.
- `dat_o`, out, 1: pixel of the last symbol. 1 = white, 0 = black.
- `sym_err_o`, out, 1: one-cycle pulse when an invalid symbol is received while locked.
- `locked_o`, out, 1: symbol alignment is locked.
- `err_cnt_o`, out, 16: count of invalid symbols. See Configuration.

## Operation
- **Bit order:** symbols are LSB first. Bit 0 is the `re` bit of a cycle.
- **Tokens:**
  - `CTL_00` = 10'b1101010100
  - `DAT_EF` = 10'b1011110000 (white)
  - `DAT_10` = 10'b0111110000 (black)
- **Window:** `win[11:0]` shifts by two bits per cycle: `win <= {tmds_fe_i, tmds_re_i, win[11:2]}`.
- **Offset state:**
  - `phase` counts 0–4 and `half` is 0–1, giving 10 possible offsets.
  - Candidate symbol is `win[11:2]` when `half`=0 and `win[10:1]` when `half`=1.
- **Strobe:** a free-running 0–4 counter `cnt`. The strobe occurs in any cycle where `cnt == phase`.
- **Slip:** if `half`=0, set `half`=1. Otherwise set `half`=0 and advance `phase` modulo 5.
  - Takes effect for the next strobe comparison.
  - No repeated rotation of `CTL_00` equals `CTL_00`, so the aligned offset is unique.
- **State machine**, evaluated on strobe cycles only:
  - **SEARCH:** candidate == `CTL_00` → VERIFY with `run`=1. Otherwise slip.
  - **VERIFY:**
    - Candidate == `CTL_00` → `run`+1; when `run` reaches `LOCK_RUN`, go to LOCKED.
    - Otherwise slip, `run`=0, go to SEARCH.
  - **LOCKED:** decode the candidate.
    - `CTL_00` → `de`=0, `dat`=0.
    - `DAT_EF` → `de`=1, `dat`=1.
    - `DAT_10` → `de`=1, `dat`=0.
    - Anything else → `de`=0, `dat`=0, `sym_err_o` pulse, `errs`+1.
    - Any valid symbol clears `errs`.
    - `errs` reaching `UNLOCK_ERR` → SEARCH, `locked_o`=0, with no slip.
- **Outputs while not locked:**
  - `valid_o` = 0 and `sym_err_o` = 0.
  - `de_o` and `dat_o` are held at 0.
- **Reset values:**
  - State SEARCH, `phase`=0, `half`=0, `cnt`=0, `win`=0.
  - `run`=0 and `errs`=0.
  - All outputs 0, including `err_cnt_o`.
- **Reset mid-operation:** returns to SEARCH immediately. No partial symbol is emitted.

## Timing
- **Registered outputs:** all outputs are registered.
- **Latency:** `valid_o`, `de_o`, `dat_o` and `sym_err_o` assert 2 `clk_i` after the cycle in which the symbol's last bit pair is present on `tmds_*_i`.
- **Symbol spacing:** while locked, `valid_o` pulses exactly every 5 cycles.
- **Slip intervals:** during search, a `phase` advance spaces consecutive strobes by 6 cycles; a 4→0 wrap spaces them by 1 cycle.
- **`locked_o` rise:** asserts in the same cycle as the first `valid_o`. That first pulse carries the `LOCK_RUN`-th `CTL_00` with `de_o`=0.
- **`locked_o` fall:** deasserts together with the `UNLOCK_ERR`-th `sym_err_o`.
- **Lock time:** at most 10 slips plus `LOCK_RUN` symbols of continuous blanking.

## Configuration
- **`DVI_BW_RX_ERR_CNT_EN` defined:**
  - `err_cnt_o` increments by 1 on every `sym_err_o`.
  - It saturates at 16'hFFFF.
  - It is cleared only by `rst_i`.
  - It is not cleared by unlock.
- **`DVI_BW_RX_ERR_CNT_EN` undefined:**
  - `err_cnt_o` is tied to 16'h0000.
  - No counter logic is present.
  - All other behaviour is identical.

## Test plan
- **Aligned lock:** stream of 20 `CTL_00` symbols, aligned.
  - `locked_o`=1 after the 16th symbol.
  - `valid_o` then pulses every 5 cycles with `de_o`=0.
- **Misaligned lock:** same stream delayed by 7 bits, followed by 40 `CTL_00` symbols.
  - Lock acquired within 10+16 symbols.
  - Decoded `de_o`=0 throughout.
- **Pixel decode:** once locked, send `DAT_EF`, `DAT_10`, `DAT_EF`, `CTL_00`.
  - Expected `(de_o, dat_o)` sequence: (1,1), (1,0), (1,1), (0,0).
  - `sym_err_o` never asserts.
- **Error handling:** once locked, send 3 symbols of 10'h000, then `DAT_EF`, then 4 symbols of 10'h000.
  - 7 `sym_err_o` pulses in total.
  - `locked_o` stays 1 through the first three, then falls on the 7th pulse.
  - With `DVI_BW_RX_ERR_CNT_EN` defined, `err_cnt_o`=7.
- **Reset mid-operation:** assert `rst_i` mid-frame while locked.
  - All outputs are 0 while reset is asserted.
  - After release, the block relocks on the next 16 `CTL_00` symbols.
- **Counter saturation:** with `DVI_BW_RX_ERR_CNT_EN` defined, force 65540 invalid symbols, relocking between bursts.
  - `err_cnt_o` holds at 16'hFFFF.

Source files
------------

// File: rtl/dvi_bw_rx.sv
// Black/white DVI single-channel receiver: DDR bit pairs -> 10-bit symbol alignment -> de/dat decode.
// Define DVI_BW_RX_ERR_CNT_EN to add the saturating invalid-symbol counter on err_cnt_o.
module dvi_bw_rx #(
    parameter int LOCK_RUN   = 16,
    parameter int UNLOCK_ERR = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tmds_re_i,
    input  logic        tmds_fe_i,
    output logic        valid_o,
    output logic        de_o,
    output logic        dat_o,
    output logic        sym_err_o,
    output logic        locked_o,
    output logic [15:0] err_cnt_o
);
    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] DAT_EF = 10'b1011110000;
    localparam logic [9:0] DAT_10 = 10'b0111110000;
    localparam int RW = $clog2(LOCK_RUN + 1);
    localparam int EW = $clog2(UNLOCK_ERR + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [11:0]   win_q;
    logic [2:0]    cnt_q, phase_q, phase_d;
    logic          half_q, half_d, skip_q, skip_d;
    logic [RW-1:0] run_q, run_d;
    logic [EW-1:0] errs_q, errs_d;
    logic          valid_d, de_d, dat_d, err_d, slip;
    logic          strobe;
    logic [9:0]    cand;

    // Newest pair lands in win[11:10]; half=1 looks one bit further back.
    assign cand   = half_q ? win_q[10:1] : win_q[11:2];
    assign strobe = (cnt_q == phase_q) && !skip_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        half_d  = half_q;
        skip_d  = 1'b0;
        run_d   = run_q;
        errs_d  = errs_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        de_d    = de_o;
        dat_d   = dat_o;
        slip    = 1'b0;
        if (strobe) begin
            unique case (state_q)
                SEARCH: begin
                    if (cand == CTL_00) begin
                        run_d = RW'(1);
                        if (LOCK_RUN <= 1) begin
                            state_d = LOCKED;
                            valid_d = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end else begin
                        slip = 1'b1;
                    end
                end
                VERIFY: begin
                    if (cand == CTL_00) begin
                        run_d = run_q + 1'b1;
                        if (run_d == RW'(LOCK_RUN)) begin
                            state_d = LOCKED;
                            valid_d = 1'b1;
                        end
                    end else begin
                        slip    = 1'b1;
                        run_d   = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    valid_d = 1'b1;
                    errs_d  = '0;
                    de_d    = 1'b0;
                    dat_d   = 1'b0;
                    case (cand)
                        CTL_00: ;
                        DAT_EF: begin
                            de_d  = 1'b1;
                            dat_d = 1'b1;
                        end
                        DAT_10: de_d = 1'b1;
                        default: begin
                            err_d  = 1'b1;
                            errs_d = errs_q + 1'b1;
                            // Losing lock keeps the current offset: no slip on the way out.
                            if (errs_d == EW'(UNLOCK_ERR)) begin
                                state_d = SEARCH;
                                valid_d = 1'b0;
                                errs_d  = '0;
                                run_d   = '0;
                            end
                        end
                    endcase
                end
                default: state_d = SEARCH;
            endcase
        end
        // A phase advance without wrap skips the very next cnt match, so strobes land 6 cycles apart.
        if (slip) begin
            if (!half_q) begin
                half_d = 1'b1;
            end else begin
                half_d = 1'b0;
                if (phase_q == 3'd4) begin
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                    skip_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SEARCH;
            win_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= '0;
            half_q    <= 1'b0;
            skip_q    <= 1'b0;
            run_q     <= '0;
            errs_q    <= '0;
            valid_o   <= 1'b0;
            de_o      <= 1'b0;
            dat_o     <= 1'b0;
            sym_err_o <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            win_q     <= {tmds_fe_i, tmds_re_i, win_q[11:2]};
            cnt_q     <= (cnt_q == 3'd4) ? 3'd0 : cnt_q + 1'b1;
            state_q   <= state_d;
            phase_q   <= phase_d;
            half_q    <= half_d;
            skip_q    <= skip_d;
            run_q     <= run_d;
            errs_q    <= errs_d;
            valid_o   <= valid_d;
            de_o      <= de_d;
            dat_o     <= dat_d;
            sym_err_o <= err_d;
            locked_o  <= (state_d == LOCKED);
        end
    end

`ifdef DVI_BW_RX_ERR_CNT_EN
    // Survives unlock; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_cnt_o <= '0;
        else if (err_d && err_cnt_o != 16'hFFFF)
            err_cnt_o <= err_cnt_o + 1'b1;
    end
`else
    assign err_cnt_o = 16'h0000;
`endif

endmodule
